// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered console UART transmitter:
// serializer state encoding and the default baud divider.
package uart_tx_buffered_pkg;

    // Clocks per bit for a 100 MHz system clock at 115200 baud.
    localparam int unsigned UART_TX_BAUD_PERIOD = 868;

    // Serializer FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage : uart_tx_buffered_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a show-ahead
// read port (dout always presents the head entry).
// DEPTH must be a power of 2 (minimum 2) so the pointers wrap by overflow.
// A push while full is ignored, even if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_ok;
    logic             pop_ok;

    // Next pointer/count/flag values; acceptance uses the flags from before this edge.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        push_ok  = push && !full_q;
        pop_ok   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (sync_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; a slot is only read after it has been written.
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule : sync_fifo

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. CPU byte writes land in a sync_fifo and a
// serializer drains it onto a registered TXD line, LSB first. When the FIFO
// still holds data at the end of a stop bit, the next start bit follows
// with no idle gap.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int unsigned BAUD_PERIOD = UART_TX_BAUD_PERIOD,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       enable_in,
    input  logic [7:0] data_in,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       TXD
);

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_PERIOD - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        txd_q, txd_d;
    logic        overflow_q, overflow_d;

    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (enable_in),
        .pop        (fifo_pop),
        .din        (data_in),
        .dout       (fifo_dout),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Serializer state register; reset abandons any frame and forces the line idle.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic: bit timing, shifting and FIFO pops.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    bit_cnt_d  = '0;
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    baud_cnt_d = BAUD_RELOAD;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt_q == '0) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next frame.
                        fifo_pop   = 1'b1;
                        shift_d    = fifo_dout;
                        bit_cnt_d  = '0;
                        baud_cnt_d = BAUD_RELOAD;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: TXD level for the upcoming state (registered) and sticky overflow.
    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        overflow_d = overflow_q || (enable_in && fifo_full);
    end

    assign TXD      = txd_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule : uart_tx_buffered
